// File: rtl/capture_snapshot_tx.sv
// Capture-timing snapshot transmitter.
// A trigger copies cap_data into a shadow register. The shadow is then sent
// LSB-first over a 1-bit stream, followed by one even-parity bit.
//
// Handshake: a bit transfers on a rising edge where ser_valid && ser_ready.
// While ser_valid=1 and ser_ready=0, ser_data and ser_last hold their value.
// ser_valid drops only after the parity bit transfers with no new trigger.
//
// Every output comes directly from a flop. busy mirrors ser_valid, so it also
// shows whether the FSM is outside IDLE.
module capture_snapshot_tx #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             trig,
  input  logic [WIDTH-1:0] cap_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n, idx_inc;
  logic               par_q, par_n;
  logic [WIDTH-1:0]   shadow_q, shadow_n;
  logic [CNT_W-1:0]   drop_q, drop_n, drop_inc;
  logic               data_q, data_n;
  logic               valid_q, valid_n;
  logic               last_q, last_n;
  logic               load;

  // Next-state, datapath and registered-output values for the frame FSM.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    par_n    = par_q;
    shadow_n = shadow_q;
    drop_n   = drop_q;
    data_n   = data_q;
    valid_n  = valid_q;
    last_n   = last_q;
    idx_inc  = idx_q + IDX_W'(1);
    drop_inc = (drop_q != {CNT_W{1'b1}}) ? drop_q + CNT_W'(1) : drop_q;
    // A trigger is accepted when idle, or when it coincides with the final
    // parity transfer (back-to-back frames with no idle cycle).
    load     = trig && ((state_q == IDLE) || (state_q == PAR && ser_ready));

    case (state_q)
      IDLE: begin
        valid_n = 1'b0;
      end
      DATA: begin
        if (trig) drop_n = drop_inc;
        if (ser_ready) begin
          par_n = par_q ^ data_q;
          if (idx_q == LAST_IDX) begin
            state_n = PAR;
            data_n  = par_q ^ data_q;
            last_n  = 1'b1;
          end else begin
            idx_n  = idx_inc;
            data_n = shadow_q[idx_inc];
          end
        end
      end
      PAR: begin
        if (ser_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n  = 1'b0;
          data_n  = 1'b0;
        end else if (trig) begin
          drop_n = drop_inc;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        last_n  = 1'b0;
        data_n  = 1'b0;
      end
    endcase

    if (load) begin
      shadow_n = cap_data;
      idx_n    = '0;
      par_n    = 1'b0;
      state_n  = DATA;
      data_n   = cap_data[0];
      valid_n  = 1'b1;
      last_n   = 1'b0;
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      par_q    <= 1'b0;
      shadow_q <= '0;
      drop_q   <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      par_q    <= par_n;
      shadow_q <= shadow_n;
      drop_q   <= drop_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      last_q   <= last_n;
    end
  end

  assign ser_valid = valid_q;
  assign ser_data  = data_q;
  assign ser_last  = last_q;
  assign busy      = valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_capture_snapshot_tx.sv
// Bench for capture_snapshot_tx (WIDTH=8, CNT_W=4).
// Reference model: a queue of expected {last, bit} symbols plus a count of
// remaining transfers. Accepting a trigger pushes the whole frame at once.
module tb_capture_snapshot_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             CK;
  logic             RST;
  logic             trig;
  logic [WIDTH-1:0] cap_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;
  logic             busy;
  logic [CNT_W-1:0] drop_cnt;

  capture_snapshot_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CK        (CK),
    .RST       (RST),
    .trig      (trig),
    .cap_data  (cap_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_data  (ser_data),
    .ser_last  (ser_last),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // clock / reset block
  initial CK = 1'b0;
  always #5 CK = ~CK;

  // scoreboard state
  logic [1:0] exp_q[$];
  int         rem;
  int         drop_m;
  int         n_checks;
  int         n_pass;

  typedef struct {
    logic       rst;
    logic       trg;
    logic [7:0] cap;
    logic       rdy;
    logic       e_valid;
    logic       e_data;
    logic       e_last;
    logic [3:0] e_drop;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Model update for one rising edge, driven by the spec's rules.
  task automatic model_edge(input logic r, input logic t, input logic [7:0] c, input logic rd);
    if (r) begin
      rem = 0;
      exp_q.delete();
      drop_m = 0;
    end else begin
      if (rem > 0 && rd) begin
        void'(exp_q.pop_front());
        rem--;
      end
      if (t) begin
        if (rem == 0) begin
          for (int i = 0; i < WIDTH; i++) exp_q.push_back({1'b0, c[i]});
          exp_q.push_back({1'b1, ^c});
          rem = WIDTH + 1;
        end else if (drop_m < 15) begin
          drop_m++;
        end
      end
    end
  endtask

  task automatic model_compare();
    check("busy", busy, rem > 0);
    check("ser_valid", ser_valid, rem > 0);
    check("drop_cnt", drop_cnt, drop_m);
    if (rem > 0) begin
      check("ser_data", ser_data, exp_q[0][0]);
      check("ser_last", ser_last, exp_q[0][1]);
    end
  endtask

  // driver: apply inputs, take one edge, update model, compare after the edge
  task automatic step(input logic r, input logic t, input logic [7:0] c, input logic rd);
    RST = r;
    trig = t;
    cap_data = c;
    ser_ready = rd;
    @(posedge CK);
    model_edge(r, t, c, rd);
    #1;
    model_compare();
  endtask

  logic       hold_d;
  logic       hold_l;
  logic [7:0] rc;

  initial begin
    n_checks = 0;
    n_pass = 0;
    rem = 0;
    drop_m = 0;
    RST = 1'b1;
    trig = 1'b0;
    cap_data = '0;
    ser_ready = 1'b0;

    // Basic frame, 8'hA5: bits 1,0,1,0,0,1,0,1 then parity 0
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};

    @(posedge CK);
    #1;
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].trg, vecs[i].cap, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), ser_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_valid);
      check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].e_drop);
      if (vecs[i].e_valid || vecs[i].rst) begin
        check($sformatf("vec%0d_data", i), ser_data, vecs[i].e_data);
        check($sformatf("vec%0d_last", i), ser_last, vecs[i].e_last);
      end
    end

    // Backpressure: 8'h01 with ready pattern 1,0,0 repeating; hold checks
    step(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 30 && rem > 0; i++) begin
      hold_d = ser_data;
      hold_l = ser_last;
      step(1'b0, 1'b0, 8'hFF, (i % 3) == 0);
      if ((i % 3) != 0) begin
        check("bp_hold_data", ser_data, hold_d);
        check("bp_hold_last", ser_last, hold_l);
      end
    end
    check("bp_done", busy, 1'b0);

    // Dropped triggers and saturation; cap_data churns mid-frame
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    check("drop_sat", drop_cnt, 4'hF);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1);
    check("drop_hold", drop_cnt, 4'hF);
    check("drop_frame_end", busy, 1'b0);

    // Back-to-back: 8'hFF frame, then trigger 8'h0F on its PAR transfer
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("b2b_par_last", ser_last, 1'b1);
    check("b2b_par_bit", ser_data, 1'b0);
    step(1'b0, 1'b1, 8'h0F, 1'b1);
    check("b2b_no_gap", ser_valid, 1'b1);
    check("b2b_first_bit", ser_data, 1'b1);
    check("b2b_drop_same", drop_cnt, 4'hF);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("b2b_done", busy, 1'b0);

    // Reset mid-frame: 8'h3C, reset after bit 3, then 8'h80
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("rst_mid_valid", ser_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_drop", drop_cnt, 4'h0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_mid_quiet", ser_valid, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_new_done", busy, 1'b0);

    // Reset priority over trigger
    step(1'b1, 1'b1, 8'hC3, 1'b1);
    check("rst_prio_valid", ser_valid, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_prio_idle", busy, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rc = 8'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, rc,
           $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
